load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: MIPS-style lb/lh/lw/lbu/lhu/sb/sh/sw unit with a simple memory handshake and timeout
module load_store_unit #(
   parameter int N       = 32,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       instruction,
   input  logic [N-1:0]      rs_data,
   input  logic [N-1:0]      rt_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [N/8-1:0]    mem_be,
   output logic [N-1:0]      mem_wdata,
   input  logic              mem_ack,
   input  logic [N-1:0]      mem_rdata,
   output logic              resp_valid,
   output logic [N-1:0]      resp_data,
   output logic [4:0]        resp_rt,
   output logic [1:0]        resp_err
);
   localparam int BL = N / 8;
   localparam int LB = $clog2(BL);
   localparam logic [N-1:0] M32 = {N{1'b1}} >> (N - 32);

   typedef enum logic [1:0] {IDLE, ADDR, MEM, RESP} state_t;
   state_t state, state_nx;

   logic [5:0]    op;
   logic [4:0]    rt_idx;
   logic [15:0]   imm;
   logic [N-1:0]  rs_q, rt_q, ea, sh_rd, ld_val, wd, rdata_q;
   logic [7:0]    cnt;
   logic [1:0]    err_q, err_addr, sz;
   logic [LB-1:0] lane;
   logic [BL-1:0] be;
   logic          legal, store, mis, tmo;

   // opcode[1:0] encodes the access size (00 byte, 01 half, 11 word), opcode[3] marks stores
   assign ea       = rs_q + {{(N-16){imm[15]}}, imm};
   assign lane     = ea[LB-1:0];
   assign sz       = op[1:0];
   assign store    = op[3];
   assign legal    = op[5:4] == 2'b10 && op[1:0] != 2'b10 && !(op[2] && (op[3] || op[1]));
   assign mis      = (sz == 2'b01 && ea[0]) || (sz == 2'b11 && ea[1:0] != 2'b00);
   assign err_addr = !legal ? 2'b10 : mis ? 2'b01 : 2'b00;
   assign tmo      = cnt == 8'(TIMEOUT - 1);
   assign be       = (sz == 2'b00 ? BL'(1) : sz == 2'b01 ? BL'(3) : BL'(15)) << lane;
   assign wd       = sz == 2'b00 ? {BL{rt_q[7:0]}} : sz == 2'b01 ? {(N/16){rt_q[15:0]}} : {(N/32){rt_q[31:0]}};
   assign sh_rd    = mem_rdata >> {lane, 3'b000};
   assign ld_val   = sz == 2'b00 ? {{(N-8){sh_rd[7] & ~op[2]}}, sh_rd[7:0]} :
                     sz == 2'b01 ? {{(N-16){sh_rd[15] & ~op[2]}}, sh_rd[15:0]} :
                     sh_rd[31] ? (sh_rd | ~M32) : (sh_rd & M32);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state logic: errors skip MEM, MEM leaves on ack or when the wait budget runs out
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = req_valid ? ADDR : IDLE;
         ADDR:    state_nx = err_addr != 2'b00 ? RESP : MEM;
         MEM:     state_nx = (mem_ack || tmo) ? RESP : MEM;
         default: state_nx = IDLE;
      endcase
   end

   // request capture, wait counter and response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         op      <= '0;
         rt_idx  <= '0;
         imm     <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         cnt     <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         if (state == IDLE && req_valid) begin
            op     <= instruction[31:26];
            rt_idx <= instruction[20:16];
            imm    <= instruction[15:0];
            rs_q   <= rs_data;
            rt_q   <= rt_data;
         end
         if (state == ADDR) begin
            cnt     <= '0;
            err_q   <= err_addr;
            rdata_q <= '0;
         end
         if (state == MEM) begin
            cnt     <= cnt + 8'd1;
            err_q   <= mem_ack ? 2'b00 : 2'b11;
            rdata_q <= (mem_ack && !store) ? ld_val : '0;
         end
      end
   end

   // outputs are zero outside the state that owns them
   always_comb begin
      req_ready  = state == IDLE;
      mem_req    = state == MEM;
      mem_we     = mem_req && store;
      mem_addr   = mem_req ? ea[ADDR_W+LB-1:LB] : '0;
      mem_be     = mem_req ? be : '0;
      mem_wdata  = mem_req ? wd : '0;
      resp_valid = state == RESP;
      resp_data  = resp_valid ? rdata_q : '0;
      resp_rt    = resp_valid ? rt_idx : '0;
      resp_err   = resp_valid ? err_q : '0;
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: byte-level reference model of the load/store unit checked every cycle
module tb_load_store_unit;
   localparam int TO = 16;
   localparam logic [5:0] OP_LB = 6'b100000, OP_LH = 6'b100001, OP_LW = 6'b100011, OP_LBU = 6'b100100,
                          OP_LHU = 6'b100101, OP_SB = 6'b101000, OP_SH = 6'b101001, OP_SW = 6'b101011;

   logic        clk = 0, rst = 1, req_valid = 0, mem_ack = 0;
   logic        req_ready, mem_req, mem_we, resp_valid;
   logic [31:0] instruction = 0, rs_data = 0, rt_data = 0, mem_rdata = 0;
   logic [31:0] mem_wdata, resp_data;
   logic [7:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [4:0]  resp_rt;
   logic [1:0]  resp_err;

   logic        en = 0, e_ready, e_req, e_we, e_valid;
   logic [7:0]  e_addr;
   logic [3:0]  e_be;
   logic [31:0] e_wd, e_data;
   logic [4:0]  e_rt;
   logic [1:0]  e_err;
   int checks = 0, failures = 0;
   logic [5:0]  ops [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

   load_store_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .instruction(instruction),
      .rs_data(rs_data), .rt_data(rt_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_rt(resp_rt), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int f_size(input logic [5:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         OP_LW, OP_SW:         return 4;
         default:              return 0;
      endcase
   endfunction

   function automatic logic f_store(input logic [5:0] op);
      return op == OP_SB || op == OP_SH || op == OP_SW;
   endfunction

   function automatic logic [31:0] f_ea(input logic [31:0] rs, input logic [15:0] imm);
      return rs + {{16{imm[15]}}, imm};
   endfunction

   function automatic logic [1:0] f_err(input logic [5:0] op, input logic [31:0] ea);
      int s = f_size(op);
      if (s == 0) return 2'b10;
      if (ea % s != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] f_be(input logic [5:0] op, input logic [31:0] ea);
      return 4'(((1 << f_size(op)) - 1) << (ea % 4));
   endfunction

   function automatic logic [31:0] f_wd(input logic [5:0] op, input logic [31:0] ea, input logic [31:0] rt);
      logic [31:0] wd = 0;
      logic [3:0]  b = f_be(op, ea);
      for (int i = 0; i < 4; i++)
         if (b[i]) wd[8*i +: 8] = rt[8*(i - int'(ea % 4)) +: 8];
      return wd;
   endfunction

   function automatic logic [31:0] f_ld(input logic [5:0] op, input logic [31:0] ea, input logic [31:0] rd);
      int s = f_size(op);
      logic [31:0] mask = (s == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * s)) - 32'd1;
      logic [31:0] v = (rd >> (8 * (ea % 4))) & mask;
      logic sgn = op == OP_LB || op == OP_LH || op == OP_LW;
      if (sgn && v[8*s-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic quiet(input logic rdy);
      e_ready = rdy; e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wd = 0;
      e_valid = 0; e_data = 0; e_rt = 0; e_err = 0;
   endtask

   // single compare process: every output against the model's expectation for this cycle
   always @(negedge clk) begin
      logic [31:0] m;
      if (en) begin
         for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{e_be[i]}};
         if (!e_req) m = '1;
         check("req_ready", req_ready, e_ready);
         check("mem_req", mem_req, e_req);
         check("mem_we", mem_we, e_we);
         check("mem_addr", mem_addr, e_addr);
         check("mem_be", mem_be, e_be);
         check("mem_wdata", mem_wdata & m, e_wd);
         check("resp_valid", resp_valid, e_valid);
         check("resp_data", resp_data, e_data);
         check("resp_rt", resp_rt, e_rt);
         check("resp_err", resp_err, e_err);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         req_valid = 0; mem_ack = 1'($urandom); quiet(1);
         @(posedge clk); #1;
      end
   endtask

   // ack_k: MEM cycle index of mem_ack (>= TO means never); rst_k: MEM cycle index to assert reset (-1 none)
   task automatic txn(input logic [5:0] op, input logic [31:0] rs, input logic [15:0] imm,
                      input logic [31:0] rt, input int ack_k, input logic [31:0] rd, input int rst_k);
      logic [31:0] ea = f_ea(rs, imm);
      logic [4:0]  ri = 5'($urandom);
      logic [1:0]  er = f_err(op, ea);
      logic        ok = ack_k < TO;
      req_valid = 1; instruction = {op, 5'($urandom), ri, imm}; rs_data = rs; rt_data = rt;
      mem_ack = 1'($urandom); quiet(1);
      @(posedge clk); #1;
      req_valid = 1'($urandom); instruction = $urandom; rs_data = $urandom; rt_data = $urandom;
      mem_ack = 1'($urandom); quiet(0);
      @(posedge clk); #1;
      if (er == 2'b00) begin
         for (int k = 0; k < TO; k++) begin
            mem_ack = k == ack_k; mem_rdata = mem_ack ? rd : $urandom; req_valid = 1'($urandom);
            e_req = 1; e_we = f_store(op); e_addr = ea[9:2]; e_be = f_be(op, ea); e_wd = f_wd(op, ea, rt);
            if (k == rst_k) rst = 1;
            @(posedge clk); #1;
            if (k == rst_k) begin
               rst = 0; mem_ack = 0; req_valid = 0; quiet(1);
               return;
            end
            if (k == ack_k) break;
         end
      end
      quiet(0); mem_ack = 1'($urandom); mem_rdata = $urandom; req_valid = 1'($urandom);
      e_valid = 1; e_rt = ri; e_err = er != 2'b00 ? er : ok ? 2'b00 : 2'b11;
      e_data = (er == 2'b00 && ok && !f_store(op)) ? f_ld(op, ea, rd) : 32'd0;
      @(posedge clk); #1;
      req_valid = 0; mem_ack = 0; quiet(1);
   endtask

   initial begin
      check("pin_ea", f_ea(32'd2, 16'd2), 32'd4);
      check("pin_ea_neg", f_ea(32'h10, 16'hFFFC), 32'hC);
      check("pin_be_sw", f_be(OP_SW, 32'd4), 32'hF);
      check("pin_be_sb", f_be(OP_SB, 32'd7), 32'h8);
      check("pin_wd_sb", f_wd(OP_SB, 32'd7, 32'hA5), 32'hA500_0000);
      check("pin_wd_sh", f_wd(OP_SH, 32'd2, 32'h1234), 32'h1234_0000);
      check("pin_lb", f_ld(OP_LB, 32'd2, 32'h0080_0000), 32'hFFFF_FF80);
      check("pin_lbu", f_ld(OP_LBU, 32'd2, 32'h0080_0000), 32'h0000_0080);
      check("pin_err_mis", f_err(OP_LW, 32'd6), 32'd1);
      check("pin_err_ill", f_err(6'b000000, 32'd0), 32'd2);
      rst = 1; quiet(1);
      @(posedge clk); #1;
      en = 1;
      @(posedge clk); #1;
      rst = 0;
      idle(2);
      txn(OP_SW, 32'd2, 16'd2, 32'hDEAD_BEEF, 1, 0, -1);
      txn(OP_SB, 32'd7, 16'd0, 32'h0000_00A5, 0, 0, -1);
      txn(OP_LB, 32'd2, 16'd0, 0, 0, 32'h0080_0000, -1);
      txn(OP_LBU, 32'd1, 16'd1, 0, 2, 32'h0080_0000, -1);
      txn(OP_LW, 32'd6, 16'd0, 0, 0, 0, -1);
      txn(6'b000000, 32'd6, 16'd0, 0, 0, 0, -1);
      txn(OP_LW, 32'h40, 16'd0, 0, TO, 0, -1);
      txn(OP_LW, 32'h40, 16'd0, 0, TO - 1, 32'h8765_4321, -1);
      txn(OP_LH, 32'h10, 16'hFFFE, 0, 0, 32'h8001_7FFF, -1);
      txn(OP_LHU, 32'h12, 16'd0, 0, 0, 32'h8001_7FFF, -1);
      txn(OP_SH, 32'h0, 16'd6, 32'hCAFE_F00D, 3, 0, -1);
      txn(OP_LW, 32'h40, 16'd0, 0, TO, 0, 3);
      idle(2);
      for (int n = 0; n < 250; n++) begin
         int r = $urandom % 10;
         txn(($urandom % 6 == 0) ? 6'($urandom) : ops[$urandom % 8], $urandom, 16'($urandom), $urandom,
             r == 0 ? TO : r == 1 ? TO - 1 : int'($urandom_range(0, 3)), $urandom,
             ($urandom % 25 == 0) ? int'($urandom_range(0, 2)) : -1);
         idle($urandom_range(0, 2));
      end
      en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
